if_pc_ctrl: RTL
===============

// Module: if_pc_ctrl
// PURPOSE
//  Sequencer for the IF-stage address adder in the pipelined CPU. Owns the PC register.
//  Drives the adder operands: PC+4 for sequential fetch, or branch PC+offset for a taken branch.
//  Issues instruction-memory fetches and holds the fetched word for ID under stall.
//  Applies jump/branch redirects from EX, with flush.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded on reset
//  NOP_INSTR 32'h0000_0000  value of if_instr when not valid/flushed
// PORTS
//  clk         in   1   clock; all state updates on posedge
//  reset       in   1   synchronous, active-high reset
//  add_a       out  32  IF adder operand a
//  add_b       out  32  IF adder operand b (offset)
//  add_c       in   32  IF adder sum (a+b, combinational, mod 2^32)
//  imem_req    out  1   fetch request; address = imem_addr
//  imem_addr   out  32  fetch address (= pc)
//  imem_ready  in   1   fetch complete this cycle; imem_rdata valid
//  imem_rdata  in   32  fetched instruction
//  if_valid    out  1   if_instr/if_pc hold a valid instruction for ID
//  if_instr    out  32  instruction to ID
//  if_pc       out  32  PC of if_instr
//  id_stall    in   1   ID cannot accept; hold if_* outputs
//  br_taken    in   1   EX: taken PC-relative branch
//  br_pc       in   32  EX: PC base for branch target
//  br_offset   in   32  EX: byte offset, already sign-extended/shifted
//  jmp_taken   in   1   EX: absolute jump
//  jmp_target  in   32  EX: absolute jump target
// BEHAVIOUR
//  Reset (dominates everything, any state):
//   - pc=RESET_PC; state=BOOT; if_valid=0; if_instr=NOP_INSTR; if_pc=0.
//   - imem_req=0 while in BOOT.
//  Adder mux (combinational):
//   - br_taken && !jmp_taken: add_a=br_pc, add_b=br_offset.
//   - otherwise: add_a=pc, add_b=32'd4.
//   - Sum wraps mod 2^32 (32'hFFFF_FFFC+4 -> 0); no overflow flag.
//  slot_free = !if_valid || !id_stall.
//  redirect = jmp_taken || br_taken. Priority: jmp_taken over br_taken.
//  FSM states: BOOT, FETCH, REDIR.
//   BOOT:
//    - imem_req=0; next state FETCH (exactly 1 cycle after reset deasserts).
//   FETCH:
//    - imem_req = slot_free && !redirect; imem_addr = pc.
//    - On imem_ready && imem_req: if_instr<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=add_c (pc+4).
//    - Back-to-back ready gives one instruction per cycle.
//    - If !slot_free: if_* held unchanged, pc unchanged, no request.
//    - If slot_free and no fetch completes: if_valid<=0.
//   Redirect (any state except reset):
//    - pc <= {target[31:2],2'b00}, where target = jmp_target or add_c.
//    - if_valid<=0 and if_instr<=NOP_INSTR next cycle (flush), even if id_stall=1.
//    - imem_rdata arriving in the same cycle is discarded.
//    - Next state REDIR.
//   REDIR:
//    - imem_req=0; 1 bubble cycle; next state FETCH.
//    - A new redirect in REDIR re-applies and stays in REDIR.
//  Timing:
//   - Latency redirect -> first fetch request at the new PC = 2 cycles.
//   - Fetch-complete -> if_valid = 1 cycle.
//  PC low bits [1:0] are always 00; any misaligned target is truncated.
// TESTING
//  1. reset 1 cycle, imem_ready=1 always -> imem_addr 0,4,8,...; if_pc trails by 1 cycle; first req 2 cycles after reset.
//  2. id_stall=1 for 3 cycles with if_valid=1 -> if_instr/if_pc constant, imem_req=0, pc frozen; resumes at next PC.
//  3. br_taken, br_pc=0x40, br_offset=0xFFFF_FFF0 -> flush; next request addr 0x30 after the REDIR bubble.
//  4. jmp_taken & br_taken same cycle, jmp_target=0x103 -> addr 0x100; branch ignored.
//  5. pc=0xFFFF_FFFC, fetch completes -> next imem_addr 0x0000_0000.
//  6. reset asserted in FETCH with imem_ready=1 -> data dropped; if_valid=0; pc=RESET_PC; state BOOT.

Source files
------------

// File: rtl/if_pc_ctrl.sv
// ---------------------------------------------------------------------------
// if_pc_ctrl
//   IF-stage sequencer for the pipelined CPU. Owns the PC, steers the shared
//   IF address adder (PC+4 or branch base+offset), issues instruction-memory
//   fetches, holds the fetched word for ID while ID stalls, and applies
//   jump/branch redirects from EX with a pipeline flush and one bubble cycle.
//
// Ports
//   clk, reset              clock; synchronous active-high reset
//   add_a, add_b  (out)     operands of the external IF adder
//   add_c         (in)      adder sum, a+b mod 2^32
//   imem_req      (out)     fetch request at imem_addr (= pc)
//   imem_ready    (in)      fetch completes this cycle, imem_rdata valid
//   imem_rdata    (in)      fetched instruction
//   if_valid/if_instr/if_pc (out)  instruction presented to ID
//   id_stall      (in)      ID cannot accept; hold if_* outputs
//   br_taken, br_pc, br_offset     EX taken PC-relative branch
//   jmp_taken, jmp_target          EX absolute jump (wins over branch)
// ---------------------------------------------------------------------------
module if_pc_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  input  logic [31:0] add_c,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_stall,
  input  logic        br_taken,
  input  logic [31:0] br_pc,
  input  logic [31:0] br_offset,
  input  logic        jmp_taken,
  input  logic [31:0] jmp_target
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    REDIR = 2'd2
  } state_t;

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic        if_valid_reg, if_valid_next;
  logic [31:0] if_instr_reg, if_instr_next;
  logic [31:0] if_pc_reg, if_pc_next;

  logic        slot_free;
  logic        redirect;
  logic        fetch_done;
  logic [31:0] target;

  // ID can take a new word when the holding slot is empty or being drained.
  assign slot_free  = !if_valid_reg || !id_stall;
  assign redirect   = jmp_taken || br_taken;
  assign fetch_done = imem_req && imem_ready;

  // With a jump present the adder still computes pc+4 (unused); the jump
  // target bypasses the adder entirely.
  assign target = jmp_taken ? jmp_target : add_c;

  // Adder operand mux: the adder is shared between sequential PC+4 and the
  // branch target computation.
  always_comb begin
    add_a = pc_reg;
    add_b = 32'd4;
    if (br_taken && !jmp_taken) begin
      add_a = br_pc;
      add_b = br_offset;
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= BOOT;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM: next-state logic. A redirect wins in every state, so a redirect
  // arriving during the REDIR bubble simply re-arms the bubble.
  always_comb begin
    state_next = state_reg;
    if (redirect) begin
      state_next = REDIR;
    end else begin
      case (state_reg)
        BOOT:    state_next = FETCH;
        FETCH:   state_next = FETCH;
        REDIR:   state_next = FETCH;
        default: state_next = BOOT;
      endcase
    end
  end

  // FSM: outputs. Requests are suppressed during a redirect cycle so that a
  // fetch from the now-dead path never completes.
  always_comb begin
    imem_req = 1'b0;
    if (state_reg == FETCH) begin
      imem_req = slot_free && !redirect;
    end
  end

  assign imem_addr = pc_reg;

  // Datapath next-state: PC and the ID holding slot.
  always_comb begin
    pc_next       = pc_reg;
    if_valid_next = if_valid_reg;
    if_instr_next = if_instr_reg;
    if_pc_next    = if_pc_reg;
    if (redirect) begin
      // Flush overrides a stall; any word returning this cycle is dropped.
      pc_next       = target & ALIGN_MASK;
      if_valid_next = 1'b0;
      if_instr_next = NOP_INSTR;
    end else if (state_reg == FETCH && slot_free) begin
      if (fetch_done) begin
        pc_next       = add_c & ALIGN_MASK;
        if_valid_next = 1'b1;
        if_instr_next = imem_rdata;
        if_pc_next    = pc_reg;
      end else begin
        // Slot drained with nothing to refill it.
        if_valid_next = 1'b0;
        if_instr_next = NOP_INSTR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg       <= RESET_PC;
      if_valid_reg <= 1'b0;
      if_instr_reg <= NOP_INSTR;
      if_pc_reg    <= 32'h0000_0000;
    end else begin
      pc_reg       <= pc_next;
      if_valid_reg <= if_valid_next;
      if_instr_reg <= if_instr_next;
      if_pc_reg    <= if_pc_next;
    end
  end

  assign if_valid = if_valid_reg;
  assign if_instr = if_instr_reg;
  assign if_pc    = if_pc_reg;

endmodule
